halton_req_arbiter: RTL

//  Round-robin controller sharing one halton_32bit_direct generator among NUM_REQ clients.

---
 rtl/halton_req_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/halton_req_arbiter.sv
// Round-robin front end that shares one Halton point generator among NUM_REQ clients.
// POPs return a tagged point (or a watchdog error); RESEEDs load the generator index.
module halton_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0]      req_op,
   input  logic [32*NUM_REQ-1:0]   req_seed,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [ID_W-1:0]         resp_id,
   output logic [31:0]             resp_x,
   output logic [31:0]             resp_y,
   output logic                    resp_err,
   output logic                    gen_pop,
   output logic                    gen_reseed,
   output logic [31:0]             gen_seed,
   input  logic                    gen_valid,
   input  logic [31:0]             gen_out_0,
   input  logic [31:0]             gen_out_1,
   output logic                    busy
);
   localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RESEED, S_WAIT, S_RESP} state_t;

   state_t                     state;
   logic [ID_W-1:0]            ptr;
   logic [ID_W-1:0]            hi_id, lo_id, win_id, ptr_nxt;
   logic                       hi_found, lo_found;
   logic [WD_W-1:0]            wdog;
   logic                       gen_valid_q;
   logic                       pt_edge;
   logic [NUM_REQ-1:0][31:0]   seed_arr;

   assign seed_arr = req_seed;

   // Two-pass priority scan: lowest requester at or above ptr, else lowest overall.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_id    = '0;
      lo_id    = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_found = 1'b1;
            lo_id    = ID_W'(i);
            if (i >= int'(ptr)) begin
               hi_found = 1'b1;
               hi_id    = ID_W'(i);
            end
         end
      end
   end

   assign win_id    = hi_found ? hi_id : lo_id;
   assign ptr_nxt   = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
   assign req_ready = (state == S_IDLE && !rst && lo_found) ? (NUM_REQ'(1) << win_id) : '0;
   // Only a fresh rising valid counts; a level left over from the previous point is stale.
   assign pt_edge   = gen_valid & ~gen_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         ptr         <= '0;
         wdog        <= '0;
         gen_valid_q <= 1'b0;
         resp_valid  <= 1'b0;
         resp_id     <= '0;
         resp_x      <= '0;
         resp_y      <= '0;
         resp_err    <= 1'b0;
         gen_pop     <= 1'b0;
         gen_reseed  <= 1'b0;
         gen_seed    <= '0;
         busy        <= 1'b0;
      end else begin
         gen_valid_q <= gen_valid;
         case (state)
            S_IDLE: begin
               if (lo_found) begin
                  ptr  <= ptr_nxt;
                  busy <= 1'b1;
                  if (req_op[win_id]) begin
                     gen_seed   <= seed_arr[win_id];
                     gen_reseed <= 1'b1;
                     state      <= S_RESEED;
                  end else begin
                     resp_id <= win_id;
                     wdog    <= '0;
                     gen_pop <= 1'b1;
                     state   <= S_WAIT;
                  end
               end
            end
            S_RESEED: begin
               gen_reseed <= 1'b0;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            S_WAIT: begin
               if (pt_edge) begin
                  resp_x     <= gen_out_0;
                  resp_y     <= gen_out_1;
                  resp_err   <= 1'b0;
                  resp_valid <= 1'b1;
                  gen_pop    <= 1'b0;
                  state      <= S_RESP;
               end else if (wdog == WD_W'(TIMEOUT-1)) begin
                  resp_x     <= '0;
                  resp_y     <= '0;
                  resp_err   <= 1'b1;
                  resp_valid <= 1'b1;
                  gen_pop    <= 1'b0;
                  state      <= S_RESP;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
